// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave exposing C_NUM_REGS byte-strobed registers, with optional
// read-only registers sourced from hardware and per-register access strobes.
module axil_regfile_slave #(
  parameter int                    C_S_AXI_DATA_WIDTH = 32,
  parameter int                    C_S_AXI_ADDR_WIDTH = 8,
  parameter int                    C_NUM_REGS         = 16,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [C_NUM_REGS-1:0]                    wr_pulse,
  output logic [C_NUM_REGS-1:0]                    rd_pulse
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IDXW     = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic [IDXW-1:0]         aw_idx_q, aw_idx_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [C_NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]           regs_q [C_NUM_REGS];
  logic [DW-1:0]           regs_d [C_NUM_REGS];
  logic [DW-1:0]           rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [C_NUM_REGS-1:0]   rd_pulse_q, rd_pulse_d;
  logic                    ready_en_q;

  logic [IDXW-1:0]         aw_idx_in, ar_idx_in, c_idx;
  logic [DW-1:0]           c_data;
  logic [SW-1:0]           c_strb;
  logic                    commit;
  logic                    aw_hs, w_hs, ar_hs;

  assign aw_idx_in = S_AXI_AWADDR[ADDR_LSB +: IDXW];
  assign ar_idx_in = S_AXI_ARADDR[ADDR_LSB +: IDXW];

  // Readies stay low through reset and for the edge that releases it.
  assign S_AXI_AWREADY = ready_en_q && (w_state_q == W_IDLE || w_state_q == W_WAIT_ADDR);
  assign S_AXI_WREADY  = ready_en_q && (w_state_q == W_IDLE || w_state_q == W_WAIT_DATA);
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ready_en_q && (r_state_q == R_IDLE);
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;
  assign rd_pulse      = rd_pulse_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = regs_q[g];
  end

  // Write channel: pair AW and W in either order, then commit once.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    w_state_d  = w_state_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    commit     = 1'b0;
    c_idx      = aw_idx_q;
    c_data     = wdata_q;
    c_strb     = wstrb_q;

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_idx  = aw_idx_in;
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
        end else if (aw_hs) begin
          aw_idx_d  = aw_idx_in;
          w_state_d = W_WAIT_DATA;
        end else if (w_hs) begin
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
          w_state_d = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: begin
        if (w_hs) begin
          commit = 1'b1;
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
        end
      end
      W_WAIT_ADDR: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_idx  = aw_idx_in;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase

    if (commit) begin
      w_state_d = W_RESP;
      bresp_d   = RESP_SLVERR;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (c_idx == IDXW'(i) && !C_RO_MASK[i]) begin
          bresp_d       = RESP_OKAY;
          wr_pulse_d[i] = 1'b1;
          for (int b = 0; b < SW; b++) begin
            if (c_strb[b]) regs_d[i][8*b +: 8] = c_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read channel: reads sample regs_q, so a same-cycle commit is not yet visible.
  always_comb begin
    r_state_d  = r_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_pulse_d = '0;

    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          for (int i = 0; i < C_NUM_REGS; i++) begin
            if (ar_idx_in == IDXW'(i)) begin
              rresp_d       = RESP_OKAY;
              rd_pulse_d[i] = 1'b1;
              rdata_d       = C_RO_MASK[i] ? reg_in[i*DW +: DW] : regs_q[i];
            end
          end
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    if (S_AXI_ARESET) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_pulse_q <= '0;
      ready_en_q <= 1'b0;
      // NOTE: the register file is flops, not a RAM macro, so clearing it in reset is both legal and required.
      regs_q     <= '{default: '0};
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_pulse_q <= rd_pulse_d;
      ready_en_q <= 1'b1;
      regs_q     <= regs_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                       S_AXI_ARADDR[ADDR_LSB-1:0], reg_in};

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed bench for axil_regfile_slave; B/R responses are checked by a
// scoreboard monitor against expectations queued by the stimulus.
module tb_axil_regfile_slave;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0020;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [AW-1:0]    awaddr = '0, araddr = '0;
  logic             awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic             bready = 1'b1, rready = 1'b1;
  logic [DW-1:0]    wdata = '0;
  logic [DW/8-1:0]  wstrb = '0;
  logic             awready, wready, bvalid, arready, rvalid;
  logic [1:0]       bresp, rresp;
  logic [DW-1:0]    rdata;
  logic [NR*DW-1:0] reg_out, reg_in;
  logic [NR-1:0]    wr_pulse, rd_pulse;

  int checks = 0;
  int errors = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  always #5 clk = ~clk;

  axil_regfile_slave #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW),
    .C_NUM_REGS(NR), .C_RO_MASK(RO)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per completed B or R handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) check("b_unexpected", {63'b0, bvalid}, 64'd0);
        else                check("bresp", {62'b0, bresp}, {62'b0, bq.pop_front()});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) check("r_unexpected", {63'b0, rvalid}, 64'd0);
        else                check("rdata_rresp", {30'b0, rdata, rresp}, {30'b0, rq.pop_front()});
      end
    end
  end

  // Holds valids until the requested readies are seen, then lets one edge complete the handshake.
  task automatic wait_hs(input bit want_aw, input bit want_w, input bit want_ar, input string nm);
    int n = 0;
    @(negedge clk);
    while (!((!want_aw || awready) && (!want_w || wready) && (!want_ar || arready)) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ready not seen within 20 cycles", nm);
    end
    @(posedge clk); #1;
  endtask

  task automatic wr_same(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s, input logic [1:0] exp_resp);
    bq.push_back(exp_resp);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_hs(1'b1, 1'b1, 1'b0, "wr");
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  // Called in the cycle after the commit edge: BVALID, pulse and register value.
  task automatic expect_wr(input string nm, input int idx, input logic [DW-1:0] exp_val,
                           input logic [NR-1:0] exp_pulse);
    @(negedge clk);
    check({nm, "_bvalid"}, {63'b0, bvalid}, 64'd1);
    check({nm, "_wr_pulse"}, {48'b0, wr_pulse}, {48'b0, exp_pulse});
    check({nm, "_reg"}, {32'b0, reg_out[idx*DW +: DW]}, {32'b0, exp_val});
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, "_wr_pulse_off"}, {48'b0, wr_pulse}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp_data,
                    input logic [1:0] exp_resp, input logic [NR-1:0] exp_pulse);
    rq.push_back({exp_data, exp_resp});
    araddr = a; arvalid = 1'b1;
    wait_hs(1'b0, 1'b0, 1'b1, "rd");
    arvalid = 1'b0;
    @(negedge clk);
    check("rd_pulse", {48'b0, rd_pulse}, {48'b0, exp_pulse});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reg_in = '0;
    reg_in[5*DW +: DW] = 32'hDEAD_BEEF;

    // Reset values, then readies one cycle after release.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_awready", {63'b0, awready}, 64'd0);
    check("rst_arready", {63'b0, arready}, 64'd0);
    check("rst_bvalid",  {63'b0, bvalid},  64'd0);
    check("rst_rvalid",  {63'b0, rvalid},  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_readies", {61'b0, awready, wready, arready}, 64'h7);
    @(posedge clk); #1;

    // AW and W together.
    wr_same(8'h04, 32'hA5A5_1234, 4'hF, 2'b00);
    expect_wr("w_same", 1, 32'hA5A5_1234, 16'h0002);

    // AW first, W three cycles later, single byte lane.
    bq.push_back(2'b00);
    awaddr = 8'h08; awvalid = 1'b1;
    wait_hs(1'b1, 1'b0, 1'b0, "aw_first");
    awvalid = 1'b0;
    @(negedge clk);
    check("wait_data_ready", {62'b0, awready, wready}, 64'h1);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    wdata = 32'hFFFF_FFFF; wstrb = 4'h2; wvalid = 1'b1;
    wait_hs(1'b0, 1'b1, 1'b0, "w_late");
    wvalid = 1'b0;
    expect_wr("w_aw_first", 2, 32'h0000_FF00, 16'h0004);

    // W first, AW three cycles later.
    bq.push_back(2'b00);
    wdata = 32'hFFFF_FFFF; wstrb = 4'h2; wvalid = 1'b1;
    wait_hs(1'b0, 1'b1, 1'b0, "w_first");
    wvalid = 1'b0;
    @(negedge clk);
    check("wait_addr_ready", {62'b0, awready, wready}, 64'h2);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    awaddr = 8'h10; awvalid = 1'b1;
    wait_hs(1'b1, 1'b0, 1'b0, "aw_late");
    awvalid = 1'b0;
    expect_wr("w_w_first", 4, 32'h0000_FF00, 16'h0010);

    // Zero strobe: OKAY, no data change, pulse still fires.
    wr_same(8'h04, 32'h0000_0000, 4'h0, 2'b00);
    expect_wr("w_strb0", 1, 32'hA5A5_1234, 16'h0002);

    // Out of range and read-only writes.
    wr_same(8'h40, 32'h1234_5678, 4'hF, 2'b10);
    expect_wr("w_oor", 0, 32'h0, 16'h0000);
    wr_same(8'h14, 32'h1234_5678, 4'hF, 2'b10);
    expect_wr("w_ro", 5, 32'h0, 16'h0000);

    // Reads: out of range, byte offset ignored, normal.
    rd(8'h40, 32'h0, 2'b10, 16'h0000);
    rd(8'h05, 32'hA5A5_1234, 2'b00, 16'h0002);
    rd(8'h08, 32'h0000_FF00, 2'b00, 16'h0004);

    // Read-only register held under back-pressure for five cycles.
    rready = 1'b0;
    rq.push_back({32'hDEAD_BEEF, 2'b00});
    araddr = 8'h14; arvalid = 1'b1;
    wait_hs(1'b0, 1'b0, 1'b1, "rd_hold");
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_rvalid", {63'b0, rvalid}, 64'd1);
      check("hold_rdata", {32'b0, rdata}, 64'hDEAD_BEEF);
      check("hold_rd_pulse", {48'b0, rd_pulse}, (k == 0) ? 64'h0020 : 64'h0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;

    // Read captured on the same edge as a commit to reg 3 returns the old value.
    bq.push_back(2'b00);
    rq.push_back({32'h0, 2'b00});
    awaddr = 8'h0C; wdata = 32'h1; wstrb = 4'hF; araddr = 8'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    wait_hs(1'b1, 1'b1, 1'b1, "rw_same");
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("rw_reg3", {32'b0, reg_out[3*DW +: DW]}, 64'h1);
    check("rw_pulses", {32'b0, wr_pulse, rd_pulse}, 64'h0008_0008);
    @(posedge clk); #1;
    rd(8'h0C, 32'h1, 2'b00, 16'h0008);

    // Reset while waiting for W data aborts the write.
    awaddr = 8'h04; awvalid = 1'b1;
    wait_hs(1'b1, 1'b0, 1'b0, "aw_abort");
    awvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_readies", {62'b0, awready, wready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_bvalid", {63'b0, bvalid}, 64'd0);
    check("abort_readies", {62'b0, awready, wready}, 64'h3);
    check("abort_regs_zero", {63'b0, |reg_out}, 64'd0);
    @(posedge clk); #1;
    rd(8'h04, 32'h0, 2'b00, 16'h0002);

    for (int n = 0; n < 50 && (bq.size() != 0 || rq.size() != 0); n++) @(posedge clk);
    check("bq_drained", 64'(bq.size()), 64'd0);
    check("rq_drained", 64'(rq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
